fp_mul_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision multiply sequencer. It owns a 48-bit shift-add mantissa datapath and steps each operation through multiply, normalize and round-to-nearest-even phases under an FSM. It presents valid/ready handshakes on input and output and sits between the operand issue logic and the result writeback in the FP unit. Subnormals are flushed to zero.

---
 rtl/fp_mul_seq.sv | 195 +++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier: radix-2^k shift-add mantissa product,
// then normalize and round-to-nearest-even, with valid/ready on both sides. Subnormals flush to zero.
module fp_mul_seq #(
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact,
    output logic        busy
);
    localparam int unsigned N_STEPS = 24 / RADIX_BITS;
    localparam int unsigned CNT_W   = $clog2(N_STEPS + 1);
    localparam int unsigned P_W     = 48;
    localparam int unsigned E_W     = 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MULT  = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_ROUND = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [P_W-1:0]        r_acc;
    logic [P_W-1:0]        r_ma;
    logic [23:0]           r_mb;
    logic [CNT_W-1:0]      r_cnt;
    logic signed [E_W-1:0] r_exp;
    logic                  r_sign;
    logic [31:0]           r_result;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_inexact;
    logic                  r_out_valid;
    logic                  r_busy;

    logic                  w_accept;
    logic [7:0]            w_ea;
    logic [7:0]            w_eb;
    logic                  w_special;
    logic [31:0]           w_special_res;
    logic                  w_last;
    logic [P_W-1:0]        w_pp;
    logic [22:0]           w_m;
    logic                  w_g;
    logic                  w_s;
    logic                  w_inc;
    logic [23:0]           w_m_sum;
    logic                  w_carry;
    logic signed [E_W-1:0] w_exp_fin;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

    assign w_accept = in_valid && in_ready;
    assign w_ea     = a[30:23];
    assign w_eb     = b[30:23];
    assign w_last   = (r_cnt == CNT_W'(N_STEPS - 1));
    assign w_pp     = r_ma * P_W'(r_mb[RADIX_BITS-1:0]);

    // Zero/inf/NaN operands bypass the datapath entirely
    always_comb begin
        w_special     = 1'b0;
        w_special_res = 32'h0;
        if ((w_ea == 8'hFF && w_eb == 8'h00) || (w_ea == 8'h00 && w_eb == 8'hFF)) begin
            w_special     = 1'b1;
            w_special_res = 32'h7FC00000;
        end else if (w_ea == 8'hFF || w_eb == 8'hFF) begin
            w_special     = 1'b1;
            w_special_res = {a[31] ^ b[31], 8'hFF, 23'h0};
        end else if (w_ea == 8'h00 || w_eb == 8'h00) begin
            w_special     = 1'b1;
            w_special_res = {a[31] ^ b[31], 31'h0};
        end
    end

    // Round-to-nearest-even on the normalized product
    always_comb begin
        w_m       = r_acc[46:24];
        w_g       = r_acc[23];
        w_s       = |r_acc[22:0];
        w_inc     = w_g && (w_s || w_m[0]);
        w_m_sum   = {1'b0, w_m} + 24'(w_inc);
        w_carry   = w_m_sum[23];
        w_exp_fin = r_exp + $signed({9'd0, w_carry});
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = w_special ? S_DONE : S_MULT;
            S_MULT:  if (w_last) w_state_nxt = S_NORM;
            S_NORM:  w_state_nxt = S_ROUND;
            S_ROUND: w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_cnt       <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign <= a[31] ^ b[31];
                        r_exp  <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - $signed(10'd127);
                        r_ma   <= {24'd0, 1'b1, a[22:0]};
                        r_mb   <= {1'b1, b[22:0]};
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        if (w_special) begin
                            r_result    <= w_special_res;
                            r_overflow  <= 1'b0;
                            r_underflow <= 1'b0;
                            r_inexact   <= 1'b0;
                        end
                    end
                end
                S_MULT: begin
                    r_acc <= r_acc + w_pp;
                    r_ma  <= r_ma << RADIX_BITS;
                    r_mb  <= r_mb >> RADIX_BITS;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_NORM: begin
                    if (r_acc[47]) r_exp <= r_exp + $signed(10'd1);
                    else           r_acc <= r_acc << 1;
                end
                S_ROUND: begin
                    if (w_exp_fin >= $signed(10'd255)) begin
                        r_result    <= {r_sign, 8'hFF, 23'h0};
                        r_overflow  <= 1'b1;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b1;
                    end else if (w_exp_fin <= $signed(10'd0)) begin
                        r_result    <= {r_sign, 31'h0};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b1;
                        r_inexact   <= 1'b1;
                    end else begin
                        r_result    <= {r_sign, w_exp_fin[7:0], w_m_sum[22:0]};
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= w_g | w_s;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq: expected results are queued at input handshake
// and compared, with latency, when the output handshake completes.
module tb_fp_mul_seq;
    localparam int unsigned RB = 1;
    localparam int N = 24 / RB;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic        busy;

    fp_mul_seq #(.RADIX_BITS(RB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .underflow(underflow),
        .inexact(inexact), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  fl;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        popped;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] e_res;
    logic [2:0]  e_fl;
    int          e_lat;
    logic        prev_ov = 1'b0;
    int          acc1;
    int          acc2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on input handshake, check latency on rise, compare on output handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready)
                sb.push_back('{e_res, e_fl, cyc, e_lat});
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
                else                chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                popped = sb.pop_front();
                chk("result", result, popped.res);
                chk("flags_ov_un_ix", 32'({overflow, underflow, inexact}), 32'(popped.fl));
            end
        end
        prev_ov = out_valid;
    end

    task automatic send(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] er,
                        input logic [2:0] fl, input int lat, input bit keep, output int acc);
        int n = 0;
        a = ia; b = ib; e_res = er; e_fl = fl; e_lat = lat;
        in_valid = 1'b1;
        acc = -1;
        while (acc < 0 && n < 200) begin
            @(negedge clk);
            n++;
            if (in_ready) acc = cyc;
        end
        chk("accept_timeout", 32'(acc < 0), 0);
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] er,
                      input logic [2:0] fl, input int lat);
        int acc;
        send(ia, ib, er, fl, lat, 1'b0, acc);
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; e_res = '0; e_fl = '0; e_lat = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", result, 0);
        chk("rst_flags", 32'({overflow, underflow, inexact}), 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // flags are {overflow, underflow, inexact}
        op(32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, N + 3);
        op(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b001, N + 3);
        op(32'h3FC00000, 32'h3F800003, 32'h3FC00004, 3'b001, N + 3);
        op(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b101, N + 3);
        op(32'h00800000, 32'h00800000, 32'h00000000, 3'b011, N + 3);
        op(32'h80000000, 32'h3F800000, 32'h80000000, 3'b000, 1);
        op(32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b000, 1);
        op(32'h00000000, 32'h7F800000, 32'h7FC00000, 3'b000, 1);
        op(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000, 1);
        op(32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, N + 3);
        op(32'h40400000, 32'h40400000, 32'h41100000, 3'b000, N + 3);
        op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b001, N + 3);
        op(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, N + 3);

        // Backpressure in DONE
        out_ready = 1'b0;
        send(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 3'b001, N + 3, 1'b0, acc1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait_timeout", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_result", result, 32'h3FC00002);
            chk("bp_flags", 32'({overflow, underflow, inexact}), 32'h1);
            chk("bp_ready_busy_valid", 32'({in_ready, busy, out_valid}), 32'h3);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 1);
        chk("bp_release_flags", 32'({overflow, underflow, inexact}), 0);
        @(posedge clk); #1;

        // Back-to-back issue interval
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000, N + 3, 1'b1, acc1);
        send(32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, N + 3, 1'b0, acc2);
        chk("issue_interval", 32'(acc2 - acc1), 32'(N + 4));
        drain();

        // Abort in MULT via reset
        send(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, N + 3, 1'b0, acc1);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_in_ready", 32'(in_ready), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_abort_in_ready", 32'(in_ready), 1);
        chk("post_abort_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        op(32'h40000000, 32'h40000000, 32'h40800000, 3'b000, N + 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
